serial_add_seq: RTL

//  Bit-serial adder sequencer. Accepts two WIDTH-bit operands plus carry-in over a

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/fa_cell.sv | 18 +
 rtl/serial_add_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Purpose: shared types and limits for the bit-serial adder sequencer.
// Contents: sa_state_t (sequencer state encoding), SA_MAX_WIDTH (largest legal WIDTH).
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } sa_state_t;

  localparam int SA_MAX_WIDTH = 64;

endpackage

// File: rtl/fa_cell.sv
// Purpose: 1-bit combinational full adder used as the serial adder's arithmetic cell.
// Ports:
//   a, b  in   operand bits
//   ci    in   carry-in
//   s     out  sum bit
//   co    out  carry-out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Purpose: bit-serial adder sequencer. Captures two WIDTH-bit operands and a carry-in,
//   feeds one bit pair per clock (LSB first) through a single fa_cell, and returns the
//   WIDTH-bit sum plus carry-out over a valid/ready handshake.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start_valid  in   a_i/b_i/cin valid
//   start_ready  out  idle, operands can be accepted
//   a_i, b_i     in   operands (WIDTH)
//   cin          in   carry-in
//   sum_o        out  (a_i + b_i + cin) mod 2^WIDTH, registered
//   cout         out  carry-out, registered
//   done_valid   out  sum_o/cout valid
//   done_ready   in   consumer accepts result
//
// state | meaning
// IDLE  | waiting for operands, start_ready=1
// RUN   | one bit per edge through the adder cell, WIDTH edges
// DONE  | result presented, waiting for done_ready
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_width_check
    $error("serial_add_seq: WIDTH out of range");
  end

  sa_state_t        state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             co;

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (s),
    .co (co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB-first stream is aligned.
  // Written as shift + bit insert so WIDTH=1 needs no zero-width slice.
  always_comb begin
    sum_nxt            = sum_sh >> 1;
    sum_nxt[WIDTH-1]   = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      sum_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum_o       <= '0;
      cout        <= 1'b0;
      done_valid  <= 1'b0;
      start_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh        <= a_i;
            b_sh        <= b_i;
            carry       <= cin;
            cnt         <= '0;
            start_ready <= 1'b0;
            state       <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_nxt;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= co;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            // Capture the result straight from the last cell evaluation so it is
            // valid in the same cycle done_valid rises.
            sum_o      <= sum_nxt;
            cout       <= co;
            done_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          done_valid  <= 1'b0;
          start_ready <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
